// File: rtl/ext_irq_controller.sv
// External interrupt controller: per-source synchroniser and gateway, priority arbitration
// against a threshold, and a claim/complete register interface driving meip.
module ext_irq_controller #(
    parameter int unsigned NUM_SRC   = 8,
    parameter int unsigned PRIO_W    = 3,
    parameter logic [31:0] EDGE_MASK = 32'h0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_SRC-1:0] i_irq_src,
    input  logic               i_req,
    input  logic               i_we,
    input  logic [5:0]         i_addr,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    output logic               o_ack,
    output logic               o_meip,
    output logic [4:0]         o_irq_id
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StResp = 1'b1;

    localparam logic [5:0] AddrEnable    = 6'h00;
    localparam logic [5:0] AddrPending   = 6'h01;
    localparam logic [5:0] AddrThreshold = 6'h02;
    localparam logic [5:0] AddrClaim     = 6'h03;

    logic [NUM_SRC-1:0] sync1_q, sync2_q, sync_prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [PRIO_W-1:0]  threshold_q, threshold_d;
    logic [PRIO_W-1:0]  prio_q [NUM_SRC];
    logic [PRIO_W-1:0]  prio_d [NUM_SRC];
    logic [0:0]         state_q, state_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [4:0]         irq_id_q;
    logic               meip_q;

    logic               access, wr_acc, rd_acc, claim, complete;
    logic [PRIO_W-1:0]  best_prio;
    logic [4:0]         best_idx;
    logic [4:0]         best_id;
    logic [4:0]         cmpl_id;

    logic unused_wdata;
    assign unused_wdata = ^i_wdata;

    // Accesses are only accepted while idle; a request during the response cycle is dropped.
    assign access   = i_req && (state_q == StIdle);
    assign wr_acc   = access && i_we;
    assign rd_acc   = access && !i_we;
    assign claim    = rd_acc && (i_addr == AddrClaim);
    assign complete = wr_acc && (i_addr == AddrClaim);
    assign cmpl_id  = i_wdata[4:0];

    // Two-flop synchroniser plus one extra stage of history for rising-edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync_prev_q <= '0;
        end else begin
            sync1_q     <= i_irq_src;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
        end
    end

    // Pick the highest-priority eligible source; ascending scan with strict > keeps lowest ID.
    always_comb begin
        best_prio = '0;
        best_idx  = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (pending_q[k] && enable_q[k] && (prio_q[k] > best_prio)) begin
                best_prio = prio_q[k];
                best_idx  = 5'(k);
            end
        end
        best_id = (best_prio > threshold_q) ? (best_idx + 5'd1) : 5'd0;
    end

    // Gateways set pending; a claim on the same edge wins; complete only frees in_service.
    always_comb begin
        pending_d    = pending_q;
        in_service_d = in_service_q;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (!in_service_q[k]) begin
                if (EDGE_MASK[k]) begin
                    if (sync2_q[k] && !sync_prev_q[k]) pending_d[k] = 1'b1;
                end else begin
                    if (sync2_q[k]) pending_d[k] = 1'b1;
                end
            end
            if (claim && (best_id != 5'd0) && (best_idx == 5'(k))) begin
                pending_d[k]    = 1'b0;
                in_service_d[k] = 1'b1;
            end
            if (complete && (cmpl_id == 5'(k + 1))) begin
                in_service_d[k] = 1'b0;
            end
        end
    end

    // Configuration register writes commit on the request edge.
    always_comb begin
        enable_d    = enable_q;
        threshold_d = threshold_q;
        prio_d      = prio_q;
        if (wr_acc && (i_addr == AddrEnable))    enable_d    = i_wdata[NUM_SRC-1:0];
        if (wr_acc && (i_addr == AddrThreshold)) threshold_d = i_wdata[PRIO_W-1:0];
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (wr_acc && (i_addr == 6'(16 + k))) prio_d[k] = i_wdata[PRIO_W-1:0];
        end
    end

    // Read data is captured at the request edge and presented during the response cycle.
    always_comb begin
        rdata_d = '0;
        if (rd_acc) begin
            case (i_addr)
                AddrEnable:    rdata_d[NUM_SRC-1:0] = enable_q;
                AddrPending:   rdata_d[NUM_SRC-1:0] = pending_q;
                AddrThreshold: rdata_d[PRIO_W-1:0]  = threshold_q;
                AddrClaim:     rdata_d[4:0]         = best_id;
                default: begin
                    for (int k = 0; k < int'(NUM_SRC); k++) begin
                        if (i_addr == 6'(16 + k)) rdata_d[PRIO_W-1:0] = prio_q[k];
                    end
                end
            endcase
        end
    end

    // Bus handshake: one response cycle per accepted request.
    always_comb begin
        state_d = StIdle;
        if (state_q == StIdle && i_req) state_d = StResp;
    end

    // Interrupt and configuration state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_q    <= '0;
            in_service_q <= '0;
            enable_q     <= '0;
            threshold_q  <= '0;
            for (int k = 0; k < int'(NUM_SRC); k++) prio_q[k] <= '0;
        end else begin
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            enable_q     <= enable_d;
            threshold_q  <= threshold_d;
            prio_q       <= prio_d;
        end
    end

    // Bus FSM, read data and registered interrupt outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            rdata_q  <= '0;
            irq_id_q <= '0;
            meip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            irq_id_q <= best_id;
            meip_q   <= (best_id != 5'd0);
        end
    end

    assign o_ack    = (state_q == StResp);
    assign o_rdata  = (state_q == StResp) ? rdata_q : '0;
    assign o_meip   = meip_q;
    assign o_irq_id = irq_id_q;

endmodule

// File: tb/tb_ext_irq_controller.sv
// Bench for ext_irq_controller: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the controller.
module tb_ext_irq_controller;

    localparam int unsigned NSRC  = 8;
    localparam int unsigned PW    = 3;
    localparam logic [31:0] EMASK = 32'h2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NSRC-1:0] irq_src = '0;
    logic            req = 1'b0;
    logic            we = 1'b0;
    logic [5:0]      addr = '0;
    logic [31:0]     wdata = '0;
    logic [31:0]     rdata;
    logic            ack;
    logic            meip;
    logic [4:0]      irq_id;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    logic [NSRC-1:0] m_pend, m_ins, m_en;
    logic [NSRC-1:0] h0, h1, h2;  // input samples from the last three edges
    int              m_thr;
    int              m_prio [NSRC];
    bit              m_busy;
    bit              e_ack, e_meip;
    logic [31:0]     e_rdata;
    int              e_id;

    ext_irq_controller #(
        .NUM_SRC  (NSRC),
        .PRIO_W   (PW),
        .EDGE_MASK(EMASK)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_irq_src(irq_src),
        .i_req    (req),
        .i_we     (we),
        .i_addr   (addr),
        .i_wdata  (wdata),
        .o_rdata  (rdata),
        .o_ack    (ack),
        .o_meip   (meip),
        .o_irq_id (irq_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Highest priority wins, lowest ID on ties, must beat the threshold.
    function automatic int m_best();
        int bp = 0;
        int bid = 0;
        for (int id = 1; id <= int'(NSRC); id++) begin
            if (m_pend[id-1] && m_en[id-1] && m_prio[id-1] > bp) begin
                bp  = m_prio[id-1];
                bid = id;
            end
        end
        return (bp > m_thr) ? bid : 0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_ins = '0; m_en = '0; m_thr = 0; m_busy = 0;
        h0 = '0; h1 = '0; h2 = '0;
        for (int k = 0; k < int'(NSRC); k++) m_prio[k] = 0;
        e_ack = 0; e_meip = 0; e_rdata = '0; e_id = 0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_edge();
        int best, id, pi;
        logic [NSRC-1:0] s, sp, np, ni;
        logic [31:0] rd;
        bit acc;
        best = m_best();
        s = h1; sp = h2; np = m_pend; ni = m_ins; rd = '0;
        for (int k = 0; k < int'(NSRC); k++) begin
            if (!m_ins[k] && (EMASK[k] ? (s[k] && !sp[k]) : s[k])) np[k] = 1'b1;
        end
        acc = req && !m_busy;
        pi = int'(addr) - 16;
        if (acc && we) begin
            if (addr == 6'h00) m_en = wdata[NSRC-1:0];
            else if (addr == 6'h02) m_thr = int'(wdata[PW-1:0]);
            else if (addr == 6'h03) begin
                id = int'(wdata[4:0]);
                if (id >= 1 && id <= int'(NSRC)) ni[id-1] = 1'b0;
            end else if (pi >= 0 && pi < int'(NSRC)) m_prio[pi] = int'(wdata[PW-1:0]);
        end else if (acc) begin
            if (addr == 6'h00) rd = 32'(m_en);
            else if (addr == 6'h01) rd = 32'(m_pend);
            else if (addr == 6'h02) rd = 32'(m_thr);
            else if (addr == 6'h03) begin
                rd = 32'(best);
                if (best != 0) begin
                    np[best-1] = 1'b0;
                    ni[best-1] = 1'b1;
                end
            end else if (pi >= 0 && pi < int'(NSRC)) rd = 32'(m_prio[pi]);
        end
        m_pend = np; m_ins = ni;
        e_ack = acc; e_rdata = rd; m_busy = acc;
        e_id = best; e_meip = (best != 0);
        h2 = h1; h1 = h0; h0 = irq_src;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("ack", 32'(ack), 32'(e_ack));
        check("rdata", rdata, e_rdata);
        check("meip", 32'(meip), 32'(e_meip));
        check("irq_id", 32'(irq_id), 32'(e_id));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic bus(input bit w, input logic [5:0] a, input logic [31:0] d,
                       output logic [31:0] rd);
        req = 1'b1; we = w; addr = a; wdata = d;
        cycle();
        rd = rdata;
        req = 1'b0; we = 1'b0;
        cycle();
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(1'b1, a, d, dummy);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; irq_src = '0; req = 1'b0; we = 1'b0;
        #1;
        model_reset();
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_meip"}, 32'(meip), 32'd0);
        check({tag, "_irq_id"}, 32'(irq_id), 32'd0);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse1();
        irq_src[1] = 1'b1; cycles(2);
        irq_src[1] = 1'b0; cycles(2);
    endtask

    initial begin
        logic [31:0] rd;
        model_reset();
        #1;
        do_reset("reset");

        // Level source 2: latency and claim/complete.
        wr(6'h00, 32'h04);
        wr(6'h12, 32'd3);
        irq_src[2] = 1'b1;
        cycles(3);
        check("lat_meip_early", 32'(meip), 32'd0);
        cycle();
        check("lat_meip", 32'(meip), 32'd1);
        check("lat_id", 32'(irq_id), 32'd3);
        bus(1'b0, 6'h03, '0, rd);
        check("claim_src2", rd, 32'd3);
        bus(1'b0, 6'h01, '0, rd);
        check("pending_after_claim", rd, 32'd0);
        check("meip_after_claim", 32'(meip), 32'd0);
        wr(6'h03, 32'd3);
        cycle();
        check("repend_meip", 32'(meip), 32'd1);
        irq_src[2] = 1'b0;
        cycles(3);
        bus(1'b0, 6'h03, '0, rd);
        wr(6'h03, 32'd3);

        // Priority ordering and tie-breaking.
        wr(6'h10, 32'd2);
        wr(6'h15, 32'd2);
        wr(6'h13, 32'd5);
        wr(6'h00, 32'h2D);
        irq_src[0] = 1'b1; irq_src[3] = 1'b1; irq_src[5] = 1'b1;
        cycles(4);
        bus(1'b0, 6'h03, '0, rd); check("claim_order_1", rd, 32'd4);
        bus(1'b0, 6'h03, '0, rd); check("claim_order_2", rd, 32'd1);
        bus(1'b0, 6'h03, '0, rd); check("claim_order_3", rd, 32'd6);
        bus(1'b0, 6'h03, '0, rd); check("claim_order_4", rd, 32'd0);
        irq_src = '0;
        cycles(3);
        wr(6'h03, 32'd4); wr(6'h03, 32'd1); wr(6'h03, 32'd6);

        // Threshold boundary.
        wr(6'h02, 32'd5);
        irq_src[3] = 1'b1;
        cycles(4);
        check("thr_eq_meip", 32'(meip), 32'd0);
        bus(1'b0, 6'h03, '0, rd); check("thr_eq_claim", rd, 32'd0);
        wr(6'h02, 32'd4);
        check("thr_lower_meip", 32'(meip), 32'd1);
        bus(1'b0, 6'h03, '0, rd); check("thr_lower_claim", rd, 32'd4);
        irq_src[3] = 1'b0;
        cycles(3);
        wr(6'h03, 32'd4);
        wr(6'h02, 32'd0);

        // Edge source 1: pulses while in service are dropped.
        wr(6'h00, 32'h02);
        wr(6'h11, 32'd1);
        pulse1();
        cycles(3);
        bus(1'b0, 6'h03, '0, rd); check("edge_claim", rd, 32'd2);
        pulse1(); pulse1(); pulse1();
        cycles(3);
        bus(1'b0, 6'h01, '0, rd); check("edge_dropped", rd, 32'd0);
        wr(6'h03, 32'd2);
        pulse1();
        cycles(3);
        bus(1'b0, 6'h01, '0, rd); check("edge_after_complete", rd, 32'h02);

        // Randomized traffic, including requests issued during the response cycle.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < int'(NSRC); k++) begin
                if ($urandom_range(0, 7) == 0) irq_src[k] = ~irq_src[k];
            end
            req = ($urandom_range(0, 2) == 0);
            we  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 6))
                0: addr = 6'h00;
                1: addr = 6'h01;
                2: addr = 6'h02;
                3, 4: addr = 6'h03;
                5: addr = 6'(16 + $urandom_range(0, 9));
                default: addr = 6'($urandom_range(0, 63));
            endcase
            wdata = (addr == 6'h03) ? 32'($urandom_range(0, 9)) : $urandom;
            cycle();
        end
        req = 1'b0; we = 1'b0;
        cycle();

        // Reset while a source is in service and an ack is in flight.
        do_reset("reset2");
        wr(6'h00, 32'hFF);
        wr(6'h14, 32'd7);
        irq_src[4] = 1'b1;
        cycles(5);
        req = 1'b1; we = 1'b0; addr = 6'h03;
        cycle();
        check("pre_reset_ack", 32'(ack), 32'd1);
        check("pre_reset_claim", rdata, 32'd5);
        do_reset("reset_mid");
        cycles(3);
        bus(1'b0, 6'h01, '0, rd); check("pending_after_reset", rd, 32'd0);
        bus(1'b0, 6'h00, '0, rd); check("enable_after_reset", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
